// File: rtl/div_pipelined_sat.sv
// Signed fixed-point pipelined divider: restoring division one quotient bit per stage,
// programmable binary point, saturation, optional round-half-even, valid/ready with tag.
module div_pipelined_sat #(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 14,
  parameter int unsigned ROUND = 1,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_dividend,
  input  logic [W-1:0]    in_divisor,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_quotient,
  output logic [TAGW-1:0] out_tag,
  output logic            out_ovf,
  output logic            out_dbz,
  output logic            busy
);

  localparam int unsigned W2 = 2 * W;
  localparam logic [W-1:0] Q_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Q_MIN = {1'b1, {(W-1){1'b0}}};

  // Whole pipeline moves in lockstep; only a held output blocks it.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Index 0 is the sign/check stage, index k (1..W) the k-th division stage.
  logic [W:0]      v;
  logic [W:0]      neg;
  logic [W:0]      dbz;
  logic [W:0]      ovf;
  logic [W2-1:0]   rem [0:W];
  logic [W-1:0]    dvs [0:W-1];
  logic [W-1:0]    qb  [0:W];
  logic [TAGW-1:0] tg  [0:W];

  // Magnitudes; |MIN| = 2^(W-1) is representable as W-bit unsigned.
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         pre_ovf;

  always_comb begin
    a_mag   = in_dividend[W-1] ? -in_dividend : in_dividend;
    b_mag   = in_divisor[W-1]  ? -in_divisor  : in_divisor;
    pre_ovf = W2'(a_mag) >= (W2'(b_mag) << (W - 1 - FRAC));
  end

  // Trial subtraction for each stage; stage k+1 decides quotient bit W-1-k.
  logic [W2-1:0] sub_v [0:W-1];
  logic [W-1:0]  bit_v [0:W-1];
  logic [W-1:0]  ge;

  always_comb begin
    for (int unsigned k = 0; k < W; k++) begin
      sub_v[k] = W2'(dvs[k]) << (W - 1 - k);
      bit_v[k] = W'(1) << (W - 1 - k);
      ge[k]    = rem[k] >= sub_v[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      neg <= '0;
      dbz <= '0;
      ovf <= '0;
      for (int unsigned k = 0; k <= W; k++) begin
        rem[k] <= '0;
        qb[k]  <= '0;
        tg[k]  <= '0;
      end
      for (int unsigned k = 0; k < W; k++) begin
        dvs[k] <= '0;
      end
    end else if (advance) begin
      v[0]   <= in_valid;
      neg[0] <= in_dividend[W-1] ^ in_divisor[W-1];
      dbz[0] <= (in_divisor == '0);
      ovf[0] <= pre_ovf;
      rem[0] <= W2'(a_mag) << (FRAC + 1);
      dvs[0] <= b_mag;
      qb[0]  <= '0;
      tg[0]  <= in_tag;
      for (int unsigned k = 1; k <= W; k++) begin
        v[k]   <= v[k-1];
        neg[k] <= neg[k-1];
        dbz[k] <= dbz[k-1];
        ovf[k] <= ovf[k-1];
        tg[k]  <= tg[k-1];
        rem[k] <= ge[k-1] ? (rem[k-1] - sub_v[k-1]) : rem[k-1];
        qb[k]  <= ge[k-1] ? (qb[k-1] | bit_v[k-1]) : qb[k-1];
      end
      for (int unsigned k = 1; k < W; k++) begin
        dvs[k] <= dvs[k-1];
      end
    end
  end

  // Final stage: W-1 magnitude bits plus guard; remainder gives the sticky bit.
  logic [W-2:0] q_mag;
  logic         g_bit;
  logic         sticky;
  logic         inc;
  logic [W-1:0] q_rnd;
  logic [W-1:0] q_nxt;
  logic         ovf_nxt;

  always_comb begin
    q_mag   = qb[W][W-1:1];
    g_bit   = qb[W][0];
    sticky  = |rem[W];
    inc     = (ROUND != 0) && g_bit && (sticky || q_mag[0]);
    q_rnd   = {1'b0, q_mag} + W'(inc);
    q_nxt   = neg[W] ? -q_rnd : q_rnd;
    ovf_nxt = 1'b0;
    if (dbz[W]) begin
      // With b == 0 the sign flag equals the dividend sign.
      q_nxt = neg[W] ? Q_MIN : Q_MAX;
    end else if (ovf[W]) begin
      q_nxt   = neg[W] ? Q_MIN : Q_MAX;
      ovf_nxt = 1'b1;
    end else if (q_rnd[W-1]) begin
      q_nxt   = neg[W] ? Q_MIN : Q_MAX;
      ovf_nxt = !neg[W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_quotient <= '0;
      out_tag      <= '0;
      out_ovf      <= 1'b0;
      out_dbz      <= 1'b0;
    end else if (advance) begin
      out_valid    <= v[W];
      out_quotient <= q_nxt;
      out_tag      <= tg[W];
      out_ovf      <= ovf_nxt;
      out_dbz      <= dbz[W];
    end
  end

  assign busy = (|v) || out_valid;

endmodule

// File: tb/tb_div_pipelined_sat.sv
// Bench for div_pipelined_sat in Q1.6 (W=8, FRAC=6): directed table, stall, random
// backpressure stream against a division model, and reset with work in flight.
module tb_div_pipelined_sat;

  localparam int unsigned W    = 8;
  localparam int unsigned FRAC = 6;
  localparam int unsigned TAGW = 4;
  localparam int          LAT  = W + 2;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [W-1:0]    in_dividend;
  logic [W-1:0]    in_divisor;
  logic [TAGW-1:0] in_tag;
  logic            out_ready;

  logic            r1_in_ready, r1_out_valid, r1_ovf, r1_dbz, r1_busy;
  logic [W-1:0]    r1_q;
  logic [TAGW-1:0] r1_tag;
  logic            r0_in_ready, r0_out_valid, r0_ovf, r0_dbz, r0_busy;
  logic [W-1:0]    r0_q;
  logic [TAGW-1:0] r0_tag;

  div_pipelined_sat #(.W(W), .FRAC(FRAC), .ROUND(1), .TAGW(TAGW)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_quotient(r1_q),
    .out_tag(r1_tag), .out_ovf(r1_ovf), .out_dbz(r1_dbz), .busy(r1_busy)
  );

  div_pipelined_sat #(.W(W), .FRAC(FRAC), .ROUND(0), .TAGW(TAGW)) u_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_tag(in_tag),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_quotient(r0_q),
    .out_tag(r0_tag), .out_ovf(r0_ovf), .out_dbz(r0_dbz), .busy(r0_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q1;
    logic [7:0] q0;
    logic       ovf;
    logic       dbz;
  } vec_t;

  typedef struct {
    logic [7:0] q1;
    logic [7:0] q0;
    logic       o1;
    logic       o0;
    logic       dbz;
    logic [3:0] tag;
  } exp_t;

  vec_t vt[13];
  exp_t sbq[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, quotient} from exact integer ratio of magnitudes.
  function automatic logic [8:0] model_q(input logic [7:0] a, input logic [7:0] b, input bit rnd);
    int sa, sb, ma, mb, n, qq, rem;
    bit neg;
    logic [7:0] r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    if (mb == 0) return {1'b0, (sa < 0) ? 8'h80 : 8'h7F};
    if (ma * 64 >= mb * 128) return {1'b1, neg ? 8'h80 : 8'h7F};
    n   = ma * 64;
    qq  = n / mb;
    rem = n % mb;
    if (rnd && ((2 * rem > mb) || ((2 * rem == mb) && (qq % 2 == 1)))) qq++;
    if (qq >= 128) return neg ? {1'b0, 8'h80} : {1'b1, 8'h7F};
    r = 8'(neg ? -qq : qq);
    return {1'b0, r};
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    exp_t e;
    logic [8:0] m1, m0;
    m1    = model_q(a, b, 1'b1);
    m0    = model_q(a, b, 1'b0);
    e.q1  = m1[7:0];
    e.o1  = m1[8];
    e.q0  = m0[7:0];
    e.o0  = m0[8];
    e.dbz = (b == 8'h00);
    e.tag = tag;
    return e;
  endfunction

  // One operation into an idle pipeline; checks latency and every output field.
  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q1,
                         input logic [7:0] q0, input logic ovf, input logic dbz,
                         input logic [3:0] tag);
    int cyc;
    string id;
    id = $sformatf("a=%02h b=%02h", a, b);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = tag;
    @(negedge clk);
    in_valid = 1'b0; in_dividend = 8'($urandom); in_divisor = 8'($urandom); in_tag = 4'($urandom);
    cyc = 1;
    while (!r1_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({"latency ", id}, cyc, LAT);
    check({"q_round1 ", id}, r1_q, q1);
    check({"q_round0 ", id}, r0_q, q0);
    check({"ovf ", id}, r1_ovf, ovf);
    check({"dbz ", id}, r1_dbz, dbz);
    check({"tag ", id}, r1_tag, tag);
    check({"r0_valid ", id}, r0_out_valid, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cyc, sent, got, stale;
    logic acc_last, prev_stall;
    logic [7:0] hold_q;
    logic [3:0] hold_tag;
    exp_t e;

    n_vec = 0; n_err = 0;
    vt[0]  = '{8'h20, 8'h40, 8'h20, 8'h20, 1'b0, 1'b0};
    vt[1]  = '{8'h20, 8'hC0, 8'hE0, 8'hE0, 1'b0, 1'b0};
    vt[2]  = '{8'h80, 8'h80, 8'h40, 8'h40, 1'b0, 1'b0};
    vt[3]  = '{8'h7F, 8'h10, 8'h7F, 8'h7F, 1'b1, 1'b0};
    vt[4]  = '{8'h7F, 8'hF0, 8'h80, 8'h80, 1'b1, 1'b0};
    vt[5]  = '{8'h10, 8'h10, 8'h40, 8'h40, 1'b0, 1'b0};
    vt[6]  = '{8'h03, 8'h80, 8'hFE, 8'hFF, 1'b0, 1'b0};
    vt[7]  = '{8'h01, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[8]  = '{8'h10, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b1};
    vt[9]  = '{8'hF0, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
    vt[10] = '{8'h00, 8'h00, 8'h7F, 8'h7F, 1'b0, 1'b1};
    vt[11] = '{8'h40, 8'h60, 8'h2B, 8'h2A, 1'b0, 1'b0};  // 42.67 ulp
    vt[12] = '{8'h80, 8'h7F, 8'hBF, 8'hC0, 1'b0, 1'b0};  // -64.50 ulp

    rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; in_tag = '0;
    out_ready = 1'b0;
    #12;
    check("reset out_valid", r1_out_valid, 0);
    check("reset quotient", r1_q, 0);
    check("reset tag", r1_tag, 0);
    check("reset ovf_dbz", {r1_ovf, r1_dbz}, 0);
    check("reset busy", {r1_busy, r0_busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset", r1_in_ready, 1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vt[i].a, vt[i].b, vt[i].q1, vt[i].q0, vt[i].ovf, vt[i].dbz, 4'(i));
    end

    // Two back-to-back ops; the first is held three cycles at the output.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_dividend = 8'h20; in_divisor = 8'h40; in_tag = 4'hA;
    @(negedge clk);
    in_dividend = 8'h20; in_divisor = 8'hC0; in_tag = 4'hB;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 2;
    while (!r1_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("stall first latency", cyc, LAT);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cyc++;
      check("stall hold q", r1_q, 8'h20);
      check("stall hold tag", r1_tag, 4'hA);
    end
    out_ready = 1'b1;
    @(negedge clk);
    cyc++;
    check("stall second arrival", {r1_out_valid, r1_tag, r1_q}, {1'b1, 4'hB, 8'hE0});
    check("stall second cycle", cyc, LAT + 1 + 3);
    @(negedge clk);
    check("stall drained", r1_out_valid, 0);

    // Random stream under random backpressure, scoreboard in order.
    sent = 0; got = 0; cyc = 0; acc_last = 1'b0; prev_stall = 1'b0;
    hold_q = '0; hold_tag = '0;
    in_valid = 1'b0;
    while (got < 20 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid || acc_last) begin
        in_dividend = 8'($urandom); in_divisor = 8'($urandom); in_tag = 4'($urandom);
        if ($urandom_range(0, 7) == 0) in_divisor = 8'h00;
        if (sent < 20 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("in_ready rule", r1_in_ready, !r1_out_valid || out_ready);
      if (prev_stall) begin
        check("stream hold", {r1_out_valid, r1_tag, r1_q}, {1'b1, hold_tag, hold_q});
      end
      if (r1_out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("stream unexpected result", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("stream q_round1", r1_q, e.q1);
          check("stream q_round0", r0_q, e.q0);
          check("stream ovf", {r1_ovf, r0_ovf}, {e.o1, e.o0});
          check("stream dbz", r1_dbz, e.dbz);
          check("stream tag", r1_tag, e.tag);
        end
        got++;
      end
      prev_stall = r1_out_valid && !out_ready;
      hold_q = r1_q; hold_tag = r1_tag;
      acc_last = in_valid && r1_in_ready;
      if (acc_last) sbq.push_back(model(in_dividend, in_divisor, in_tag));
    end
    check("stream results received", got, 20);
    check("stream scoreboard empty", sbq.size(), 0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    stale = 0;
    repeat (15) begin
      @(negedge clk);
      if (r1_out_valid) stale++;
    end
    check("stream no extra results", stale, 0);

    // Five ops in flight with the first held at the output, then async reset.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_dividend = 8'h20; in_divisor = 8'h40; in_tag = 4'(i + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc = 0;
    while (!r1_out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("pre-reset result present", {r1_out_valid, r1_q}, {1'b1, 8'h20});
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", r1_out_valid, 0);
    check("midreset quotient", r1_q, 0);
    check("midreset tag_flags", {r1_tag, r1_ovf, r1_dbz}, 0);
    check("midreset busy", r1_busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("in_ready after midreset", r1_in_ready, 1);
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (r1_out_valid || r1_busy) stale++;
    end
    check("no stale after reset", stale, 0);
    run_vec(8'h40, 8'h60, 8'h2B, 8'h2A, 1'b0, 1'b0, 4'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
